// File: rtl/cdr_pkg.sv
// Shared types and arithmetic helpers for the oversampling CDR.
// Pure package: no state, no latency, no flow control.
package cdr_pkg;
   typedef enum logic [1:0] {
      ADJ_NONE = 2'd0,
      ADJ_HOLD = 2'd1,
      ADJ_SKIP = 2'd2
   } adj_t;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } lock_t;

   // Position within the symbol folded to a signed offset from the expected boundary.
   function automatic int err_fold(input int p, input int osr);
      return (p <= (osr - 1) / 2) ? p : p - osr;
   endfunction

   function automatic int sat_add(input int a, input int b, input int w);
      int s;
      int hi;
      int lo;
      s  = a + b;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction
endpackage

// File: rtl/cdr_ted.sv
// Transition detector, error fold, timing accumulator and once-per-symbol correction decision.
// o_adj/o_bad are combinational on the current sample, o_err is registered; state moves only when i_flag=1.
module cdr_ted
   import cdr_pkg::*;
#(
   parameter int OSR   = 5,
   parameter int ACC_W = 4,
   parameter int TH    = 3,
   parameter int PW    = $clog2(OSR),
   parameter int EW    = $clog2(OSR) + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic          i_flag,
   input  logic          i_phase,
   input  logic [PW-1:0] i_ph,
   output logic [1:0]    o_adj,
   output logic [EW-1:0] o_err,
   output logic          o_bad
);
   logic                    prev_q, prev_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic                    held_q, held_d;
   logic [EW-1:0]           err_q, err_d;
   adj_t                    adj;
   logic                    trans;
   int                      e;
   int                      sum;

   always_comb begin
      prev_d = prev_q;
      acc_d  = acc_q;
      held_d = held_q;
      err_d  = err_q;
      adj    = ADJ_NONE;
      o_bad  = 1'b0;
      trans  = i_phase ^ prev_q;
      e      = err_fold(int'(i_ph), OSR);
      sum    = int'(acc_q);
      if (i_clr) begin
         prev_d = 1'b0;
         acc_d  = '0;
         held_d = 1'b0;
         err_d  = '0;
      end else if (i_flag) begin
         prev_d = i_phase;
         if (trans) begin
            sum   = sat_add(int'(acc_q), e, ACC_W);
            err_d = EW'(e);
            o_bad = (e > 1) || (e < -1);
         end
         acc_d = ACC_W'(sum);
         // A held OSR-1 sample is re-evaluated but may not correct twice in one symbol.
         if (int'(i_ph) == OSR - 1) begin
            if (!held_q && sum >= TH) begin
               adj    = ADJ_HOLD;
               acc_d  = '0;
               held_d = 1'b1;
            end else if (!held_q && sum <= -TH) begin
               adj   = ADJ_SKIP;
               acc_d = '0;
            end else begin
               held_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         prev_q <= 1'b0;
         acc_q  <= '0;
         held_q <= 1'b0;
         err_q  <= '0;
      end else begin
         prev_q <= prev_d;
         acc_q  <= acc_d;
         held_q <= held_d;
         err_q  <= err_d;
      end
   end

   assign o_adj = adj;
   assign o_err = err_q;
endmodule

// File: rtl/cdr_osr.sv
// Oversampling CDR: phase counter, bit decision (single or 3-sample vote) and lock FSM around cdr_ted.
// Outputs registered, one cycle after the qualifying sample; no backpressure, i_flag gaps simply stall.
module cdr_osr
   import cdr_pkg::*;
#(
   parameter int OSR      = 5,
   parameter int ACC_W    = 4,
   parameter int TH       = 3,
   parameter int LOCK_N   = 8,
   parameter int UNLOCK_N = 4,
   parameter int VOTE     = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_flag,
   input  logic                   i_phase,
   output logic                   o_data,
   output logic                   o_flag,
   output logic                   o_lock,
   output logic [$clog2(OSR):0]   o_err,
   output logic [1:0]             o_adj
);
   localparam int C      = OSR / 2;
   localparam int PW     = $clog2(OSR);
   localparam int EW     = $clog2(OSR) + 1;
   localparam int GW     = $clog2(LOCK_N + 1);
   localparam int BW     = $clog2(UNLOCK_N + 1);
   localparam int DEC_PH = (VOTE != 0) ? C + 1 : C;

   logic [PW-1:0] ph_q, ph_d;
   logic          rep_q, rep_d;
   logic          s_lo_q, s_lo_d;
   logic          s_c_q, s_c_d;
   logic          data_q, data_d;
   logic          flag_q, flag_d;
   logic [1:0]    adj_q, adj_d;
   lock_t         lock_q, lock_d;
   logic [GW-1:0] good_q, good_d;
   logic [BW-1:0] bad_q, bad_d;
   logic          sym_bad_q, sym_bad_d;
   logic [1:0]    ted_adj_raw;
   adj_t          ted_adj;
   logic          ted_bad;
   logic          sym_bad;
   logic          maj;

   cdr_ted #(
      .OSR   (OSR),
      .ACC_W (ACC_W),
      .TH    (TH),
      .PW    (PW),
      .EW    (EW)
   ) u_ted (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr),
      .i_flag  (i_flag),
      .i_phase (i_phase),
      .i_ph    (ph_q),
      .o_adj   (ted_adj_raw),
      .o_err   (o_err),
      .o_bad   (ted_bad)
   );

   assign ted_adj = adj_t'(ted_adj_raw);
   assign maj     = (s_lo_q & s_c_q) | (s_lo_q & i_phase) | (s_c_q & i_phase);
   assign sym_bad = sym_bad_q | ted_bad;

   always_comb begin
      ph_d      = ph_q;
      rep_d     = rep_q;
      s_lo_d    = s_lo_q;
      s_c_d     = s_c_q;
      data_d    = data_q;
      flag_d    = 1'b0;
      adj_d     = ADJ_NONE;
      lock_d    = lock_q;
      good_d    = good_q;
      bad_d     = bad_q;
      sym_bad_d = sym_bad_q;
      if (i_clr) begin
         ph_d      = '0;
         rep_d     = 1'b0;
         s_lo_d    = 1'b0;
         s_c_d     = 1'b0;
         data_d    = 1'b0;
         lock_d    = HUNT;
         good_d    = '0;
         bad_d     = '0;
         sym_bad_d = 1'b0;
      end else if (i_flag) begin
         adj_d = ted_adj_raw;
         rep_d = (ted_adj == ADJ_HOLD);
         if (int'(ph_q) == OSR - 1) begin
            case (ted_adj)
               ADJ_HOLD: ph_d = ph_q;
               ADJ_SKIP: ph_d = PW'(1);
               default:  ph_d = '0;
            endcase
         end else begin
            ph_d = ph_q + PW'(1);
         end
         if (int'(ph_q) == C - 1) s_lo_d = i_phase;
         if (int'(ph_q) == C)     s_c_d  = i_phase;
         if (int'(ph_q) == DEC_PH && !rep_q) begin
            flag_d = 1'b1;
            data_d = (VOTE != 0) ? maj : i_phase;
         end
         sym_bad_d = sym_bad;
         // Symbol end is the OSR-1 sample that is not followed by a hold.
         if (int'(ph_q) == OSR - 1 && ted_adj != ADJ_HOLD) begin
            sym_bad_d = 1'b0;
            if (lock_q == HUNT) begin
               if (sym_bad) begin
                  good_d = '0;
               end else if (int'(good_q) + 1 >= LOCK_N) begin
                  good_d = GW'(LOCK_N);
                  lock_d = LOCKED;
               end else begin
                  good_d = good_q + GW'(1);
               end
            end else begin
               if (!sym_bad) begin
                  bad_d = '0;
               end else if (int'(bad_q) + 1 >= UNLOCK_N) begin
                  bad_d  = '0;
                  good_d = '0;
                  lock_d = HUNT;
               end else begin
                  bad_d = bad_q + BW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ph_q      <= '0;
         rep_q     <= 1'b0;
         s_lo_q    <= 1'b0;
         s_c_q     <= 1'b0;
         data_q    <= 1'b0;
         flag_q    <= 1'b0;
         adj_q     <= ADJ_NONE;
         lock_q    <= HUNT;
         good_q    <= '0;
         bad_q     <= '0;
         sym_bad_q <= 1'b0;
      end else begin
         ph_q      <= ph_d;
         rep_q     <= rep_d;
         s_lo_q    <= s_lo_d;
         s_c_q     <= s_c_d;
         data_q    <= data_d;
         flag_q    <= flag_d;
         adj_q     <= adj_d;
         lock_q    <= lock_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         sym_bad_q <= sym_bad_d;
      end
   end

   assign o_data = data_q;
   assign o_flag = flag_q;
   assign o_lock = (lock_q == LOCKED);
   assign o_adj  = adj_q;
endmodule

// File: tb/tb_cdr_osr.sv
// Directed bench for cdr_osr: a VOTE=1 and a VOTE=0 instance share one sample stream.
// Expected flag positions/data are hand-derived per case and compared through check().
module tb_cdr_osr;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       flag;
   logic       phase;
   logic       d1_data, d1_flag, d1_lock;
   logic [3:0] d1_err;
   logic [1:0] d1_adj;
   logic       d0_data, d0_flag, d0_lock;
   logic [3:0] d0_err;
   logic [1:0] d0_adj;

   int   nchk = 0;
   int   nerr = 0;
   int   nsamp;
   int   lock_rise, lock_fall;
   logic lock_prev;
   logic lvl;
   logic gap_en = 1'b0;
   int   idle_bad = 0;
   int   fl1_idx[$];
   int   fl0_idx[$];
   int   fl1_dat[$];
   int   fl0_dat[$];
   int   adj_idx[$];
   int   adj_val[$];
   int   ei[10];
   int   ed[10];

   always #5 clk = ~clk;

   cdr_osr #(.OSR(5), .ACC_W(4), .TH(3), .LOCK_N(8), .UNLOCK_N(4), .VOTE(1)) u_dut (
      .i_clk(clk), .i_rst(rst_n), .i_clr(clr), .i_flag(flag), .i_phase(phase),
      .o_data(d1_data), .o_flag(d1_flag), .o_lock(d1_lock), .o_err(d1_err), .o_adj(d1_adj)
   );

   cdr_osr #(.OSR(5), .ACC_W(4), .TH(3), .LOCK_N(8), .UNLOCK_N(4), .VOTE(0)) u_dut_v0 (
      .i_clk(clk), .i_rst(rst_n), .i_clr(clr), .i_flag(flag), .i_phase(phase),
      .o_data(d0_data), .o_flag(d0_flag), .o_lock(d0_lock), .o_err(d0_err), .o_adj(d0_adj)
   );

   task automatic check(input string tag, input integer got, input integer exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_logs();
      nsamp     = 0;
      lock_rise = -1;
      lock_fall = -1;
      lock_prev = 1'b0;
      fl1_idx.delete(); fl0_idx.delete();
      fl1_dat.delete(); fl0_dat.delete();
      adj_idx.delete(); adj_val.delete();
   endtask

   task automatic log_out(input int n);
      if (d1_flag) begin fl1_idx.push_back(n); fl1_dat.push_back(int'(d1_data)); end
      if (d0_flag) begin fl0_idx.push_back(n); fl0_dat.push_back(int'(d0_data)); end
      if (d1_adj != 2'd0) begin adj_idx.push_back(n); adj_val.push_back(int'(d1_adj)); end
      if (d1_lock && !lock_prev) lock_rise = n;
      if (!d1_lock && lock_prev) lock_fall = n;
      lock_prev = d1_lock;
   endtask

   task automatic idle();
      flag  = 1'b0;
      phase = 1'($urandom);
      @(posedge clk); #1;
      if (d1_flag || d0_flag || d1_adj != 2'd0) idle_bad++;
   endtask

   task automatic send(input logic v);
      if (gap_en && $urandom_range(3) == 0) idle();
      flag  = 1'b1;
      phase = v;
      @(posedge clk); #1;
      flag = 1'b0;
      log_out(nsamp);
      nsamp++;
   endtask

   // One 5-sample symbol whose level toggles at sample p (p=5: no transition).
   task automatic sym_tr(input int p);
      for (int i = 0; i < 5; i++) begin
         if (i == p) lvl = ~lvl;
         send(lvl);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, "_outs1"}, {d1_data, d1_flag, d1_lock, d1_adj, d1_err}, 0);
      check({tag, "_outs0"}, {d0_data, d0_flag, d0_lock, d0_adj, d0_err}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      lvl   = 1'b0;
      clr_logs();
   endtask

   task automatic chk_flags(input string tag, input int sel, input int n);
      int sz;
      sz = sel ? fl1_idx.size() : fl0_idx.size();
      check({tag, "_cnt"}, sz, n);
      for (int i = 0; i < n && i < sz; i++) begin
         check($sformatf("%s_idx%0d", tag, i), sel ? fl1_idx[i] : fl0_idx[i], ei[i]);
         check($sformatf("%s_dat%0d", tag, i), sel ? fl1_dat[i] : fl0_dat[i], ed[i]);
      end
   endtask

   task automatic aligned_exp(input int off);
      for (int i = 0; i < 10; i++) begin
         ei[i] = 5 * i + off;
         ed[i] = (i % 2 == 0) ? 1 : 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; flag = 1'b0; phase = 1'b0; lvl = 1'b0;
      clr_logs();
      @(posedge clk); #1;
      do_reset("rst0");

      // Aligned: transitions on the symbol boundary, lock after 8 symbols.
      for (int s = 0; s < 10; s++) sym_tr(0);
      aligned_exp(3); chk_flags("al_v1", 1, 10);
      aligned_exp(2); chk_flags("al_v0", 0, 10);
      check("al_adj_cnt", adj_idx.size(), 0);
      check("al_lock_rise", lock_rise, 39);
      check("al_err", int'($signed(d1_err)), 0);

      // Unlock: 3 bad, 1 good keeps lock; then 4 bad drops it.
      sym_tr(2); sym_tr(3); sym_tr(2); sym_tr(5);
      check("ul_held_good", d1_lock, 1);
      check("ul_err_pos", int'($signed(d1_err)), 2);
      sym_tr(3);
      check("ul_err_neg", int'($signed(d1_err)), -2);
      sym_tr(2); sym_tr(3);
      check("ul_held_3bad", d1_lock, 1);
      sym_tr(2);
      check("ul_lock_fall", lock_fall, 89);
      check("ul_adj_cnt", adj_idx.size(), 0);

      // Late: e=+1 each symbol -> hold after the third, fourth symbol is 6 samples.
      do_reset("rst_late");
      sym_tr(1);
      check("late_err", int'($signed(d1_err)), 1);
      for (int s = 0; s < 4; s++) sym_tr(1);
      check("late_adj_cnt", adj_idx.size(), 1);
      if (adj_idx.size() > 0) begin
         check("late_adj_idx", adj_idx[0], 14);
         check("late_adj_val", adj_val[0], 1);
      end
      ei[0:4] = '{3, 8, 13, 19, 24}; ed[0:4] = '{1, 0, 1, 0, 1};
      chk_flags("late_v1", 1, 5);
      ei[0:4] = '{2, 7, 12, 18, 23};
      chk_flags("late_v0", 0, 5);

      // Early: e=-1 each symbol -> skip after the third, fourth symbol is 4 samples.
      do_reset("rst_early");
      sym_tr(4);
      check("early_err", int'($signed(d1_err)), -1);
      for (int s = 0; s < 4; s++) sym_tr(4);
      check("early_adj_cnt", adj_idx.size(), 1);
      if (adj_idx.size() > 0) begin
         check("early_adj_idx", adj_idx[0], 14);
         check("early_adj_val", adj_val[0], 2);
      end
      ei[0:4] = '{3, 8, 13, 17, 22}; ed[0:4] = '{0, 1, 0, 1, 0};
      chk_flags("early_v1", 1, 5);
      ei[0:4] = '{2, 7, 12, 16, 21};
      chk_flags("early_v0", 0, 5);

      // Vote: ph1..3 = 1,0,1 then 0,1,0.
      do_reset("rst_vote");
      send(1'b0); send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      send(1'b0); send(1'b0); send(1'b1); send(1'b0); send(1'b0);
      ei[0:1] = '{3, 8}; ed[0:1] = '{1, 0};
      chk_flags("vote_v1", 1, 2);
      ei[0:1] = '{2, 7}; ed[0:1] = '{0, 1};
      chk_flags("vote_v0", 0, 2);
      check("vote_adj_cnt", adj_idx.size(), 0);

      // Random i_flag gaps must not change the decided sequence.
      do_reset("rst_gap");
      gap_en = 1'b1;
      for (int s = 0; s < 10; s++) sym_tr(0);
      gap_en = 1'b0;
      aligned_exp(3); chk_flags("gap_v1", 1, 10);
      check("gap_v0_cnt", fl0_idx.size(), 10);
      check("gap_idle_strobe", idle_bad, 0);
      check("gap_lock_rise", lock_rise, 39);

      // Async reset mid-symbol.
      send(1'b1); send(1'b1); send(1'b1); send(1'b1);
      check("pre_rst_lock", d1_lock, 1);
      check("pre_rst_data", d1_data, 1);
      do_reset("rst_mid");
      sym_tr(0); sym_tr(0);
      ei[0:1] = '{3, 8}; ed[0:1] = '{1, 0};
      chk_flags("post_rst_v1", 1, 2);

      // Clear coincident with a valid sample: clear wins.
      send(1'b1); send(1'b1); send(1'b1); send(1'b1);
      check("pre_clr_data", d1_data, 1);
      clr = 1'b1; flag = 1'b1; phase = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; flag = 1'b0;
      check("clr_outs1", {d1_data, d1_flag, d1_lock, d1_adj, d1_err}, 0);
      lvl = 1'b0;
      clr_logs();
      sym_tr(0); sym_tr(0);
      ei[0:1] = '{3, 8}; ed[0:1] = '{1, 0};
      chk_flags("post_clr_v1", 1, 2);
      ei[0:1] = '{2, 7};
      chk_flags("post_clr_v0", 0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/cdr_osr.md
Name: cdr_osr

Overview:
- Parametrised clock/data recovery for the Zigbee demodulator path. Successor to the fixed 5x CDR.
- Consumes a 1-bit phase-sign sample stream, qualified by i_flag, from the discriminator.
- Tracks symbol timing with an early/late transition detector, an integrating accumulator and a counter hold/skip.
- Delivers one decided bit per symbol with a strobe and a lock indication to the despreader.

Parameters:
- OSR, 5, samples per symbol (legal 3..16); centre index C = OSR/2 (floor).
- ACC_W, 4, signed timing accumulator width.
- TH, 3, accumulator magnitude that triggers a correction (1..2^(ACC_W-1)-1).
- LOCK_N, 8, consecutive good symbols needed to assert lock.
- UNLOCK_N, 4, consecutive bad symbols needed to drop lock.
- VOTE, 1: 0 = single sample at C; 1 = 3-sample majority at C-1, C, C+1.

Ports:
- i_clk, in, 1, system clock.
- i_rst, in, 1, asynchronous active-low reset.
- i_clr, in, 1, synchronous clear of all state (burst restart); same values as reset.
- i_flag, in, 1, sample valid strobe.
- i_phase, in, 1, phase-sign sample; meaningful only when i_flag=1.
- o_data, out, 1, decided bit; registered and held between strobes.
- o_flag, out, 1, one-cycle strobe when o_data updates.
- o_lock, out, 1, timing lock.
- o_err, out, $clog2(OSR)+1, signed error of the last transition (debug).
- o_adj, out, 2, one-cycle correction event: 0 none, 1 hold, 2 skip.

Behaviour:
- Reset (i_rst=0, async) or i_clr=1 (sync):
  - ph=0, prev=0, acc=0, both lock counters 0, lock FSM = HUNT.
  - All outputs 0.
  - i_clr has priority over i_flag in the same cycle.
- All state advances only on cycles with i_flag=1. Cycles with i_flag=0 hold all state and force o_flag=0 and o_adj=0.
- Phase counter ph:
  - Counts 0..OSR-1 and wraps.
  - Expected symbol boundary is ph=0; decision point is C.
- Transition detection:
  - t = i_phase XOR prev; prev updates on every valid sample.
  - The first sample after reset compares against prev=0.
- Error on a transition at ph=p:
  - e = p for p <= (OSR-1)/2, otherwise e = p - OSR. A transition at p=0 gives e=0.
  - o_err <= e on every transition.
  - acc <= sat(acc + e), clamped to the signed ACC_W range.
- Correction is evaluated only on the sample with ph=OSR-1, after that sample's own error is added:
  - acc >= TH: ph stays at OSR-1 for the next sample (symbol stretched by 1); acc <= 0; o_adj=1.
  - acc <= -TH: ph goes to 1 instead of 0 (symbol shortened by 1); acc <= 0; o_adj=2.
  - Otherwise: normal wrap, acc retained.
  - At most one correction per symbol. The C window is never skipped.
- Decision:
  - VOTE=0: on the sample with ph=C, o_data <= i_phase and o_flag=1 the next cycle.
  - VOTE=1: majority of the samples at C-1, C, C+1, output on the ph=C+1 sample, 1-cycle registered latency.
  - With VOTE=1, a hold at OSR-1 does not repeat the decision. Exactly one o_flag per symbol.
- Lock FSM, evaluated once per symbol at ph=OSR-1:
  - Bad symbol: any transition in the symbol with |e| > 1. Good symbol: otherwise, including no transition.
  - HUNT: a good symbol increments good_cnt (saturating); a bad symbol clears it. good_cnt reaching LOCK_N -> LOCKED, o_lock=1 from the next cycle.
  - LOCKED: a bad symbol increments bad_cnt; a good symbol clears it. bad_cnt reaching UNLOCK_N -> HUNT, o_lock=0, both counters cleared.
  - Lock has no effect on decisions.
- Simultaneous events:
  - A transition at ph=OSR-1 is accumulated before the threshold test.
  - A hold-repeated OSR-1 sample is a new sample: its transition counts and it is evaluated again (no second correction in that symbol).

Decomposition:
- Package cdr_pkg:
  - adj_t enum: ADJ_NONE, ADJ_HOLD, ADJ_SKIP.
  - lock_t enum: HUNT, LOCKED.
  - Function for the signed error fold and the saturating add.
- Sub-module cdr_ted: transition detect, error fold, accumulator and correction decision. Interface: ph in; adj and err out.
- Top level holds the phase counter, the decision voter and the lock FSM.

Test Plan:
(Defaults OSR=5, C=2, TH=3, VOTE=1.)
1. Aligned: alternating bits, 5 samples each, transitions at ph=0 -> e=0, o_adj always 0, o_flag every 5 valid samples, o_data = 1,0,1,..., o_lock rises after symbol 8.
2. Late: transitions at ph=1 every symbol -> acc 1,2,3 -> o_adj=1 at the end of symbol 3, next symbol is 6 samples long, acc back to 0.
3. Early: transitions at ph=4 (e=-1) -> o_adj=2 at the end of symbol 3, next symbol is 4 samples long; o_flag count equals the symbol count.
4. Vote: samples at ph 1,2,3 = 1,0,1 -> o_data=1; 0,1,0 -> o_data=0; VOTE=0 build, same stimulus -> o_data = sample at ph=2.
5. Unlock: when locked, 3 symbols with e=2 then a good symbol -> lock held. Then 4 bad symbols -> o_lock falls one cycle after the 4th symbol end.
6. Robustness:
   - Random i_flag gaps (25% low) -> identical o_data sequence to case 1.
   - i_rst pulled low mid-symbol -> all outputs 0 immediately, restart from ph=0.
   - i_clr together with i_flag -> clear wins.
